// File: rtl/mem_miss_controller_pkg.sv
// rtl/mem_miss_controller_pkg.sv - shared state encoding, arbitration modes and width helper
package mem_miss_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_FILL   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n items, never below one bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_miss_controller_rr_arbiter.sv
// rtl/mem_miss_controller_rr_arbiter.sv - combinational fixed-priority / round-robin request picker
module mem_miss_controller_rr_arbiter
    import mem_miss_controller_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    input  logic              rr_mode_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              valid_o
);

    int cand;

    // Scan starts at the pointer in round-robin mode and at channel 0 otherwise.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = rr_mode_i ? ((int'(ptr_i) + i) % NUM_CH) : i;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_miss_controller.sv
// rtl/mem_miss_controller.sv - services cache misses one at a time over a shared memory port
// (optional victim write-back, line fill, commit) with a memory-response watchdog.
module mem_miss_controller
    import mem_miss_controller_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ARB_MODE    = ARB_RR,
    parameter  int TIMEOUT_CYC = 255,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] req_we_i,
    input  logic [NUM_CH-1:0] req_dirty_i,
    input  logic              u_rdy_i,
    output logic              u_re_o,
    output logic              u_we_o,
    output logic              evict_o,
    output logic [CH_W-1:0]   ch_sel_o,
    output logic [NUM_CH-1:0] fill_we_o,
    output logic [NUM_CH-1:0] set_dirty_o,
    output logic [NUM_CH-1:0] done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int WD_W = ch_width(TIMEOUT_CYC + 1);

    state_t            state_q;
    logic [CH_W-1:0]   g_q;
    logic              g_we_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic [WD_W-1:0]   wd_q;
    logic              err_q;

    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_valid;
    logic              wd_expire;
    logic [NUM_CH-1:0] g_onehot;

    mem_miss_controller_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .rr_mode_i (ARB_MODE == ARB_RR),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    assign ptr_d     = (g_q == CH_W'(NUM_CH - 1)) ? '0 : g_q + 1'b1;
    // The counter holds cycles already spent waiting, so this is the last allowed cycle.
    assign wd_expire = (TIMEOUT_CYC != 0) && (32'(wd_q) == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            g_we_q  <= 1'b0;
            ptr_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        g_q     <= arb_idx;
                        g_we_q  <= |(arb_grant & req_we_i);
                        wd_q    <= '0;
                        state_q <= (|(arb_grant & req_dirty_i)) ? ST_WB : ST_FILL;
                    end
                end
                ST_WB, ST_FILL: begin
                    if (u_rdy_i) begin
                        state_q <= (state_q == ST_WB) ? ST_FILL : ST_COMMIT;
                        wd_q    <= '0;
                    end else if (wd_expire) begin
                        state_q <= ST_ABORT;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    ptr_q   <= ptr_d;
                    state_q <= ST_IDLE;
                end
                ST_ABORT: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign g_onehot    = NUM_CH'(1) << g_q;
    assign u_we_o      = (state_q == ST_WB);
    assign evict_o     = (state_q == ST_WB);
    assign u_re_o      = (state_q == ST_FILL);
    assign ch_sel_o    = g_q;
    assign fill_we_o   = (state_q == ST_COMMIT) ? g_onehot : '0;
    assign set_dirty_o = (state_q == ST_COMMIT && g_we_q) ? g_onehot : '0;
    assign done_o      = (state_q == ST_COMMIT || state_q == ST_ABORT) ? g_onehot : '0;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_mem_miss_controller.sv
// tb/tb_mem_miss_controller.sv - bench for mem_miss_controller (round-robin and fixed-priority copies)
module tb_mem_miss_controller;

    localparam int N  = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0] req_s[2], we_s[2], dirty_s[2];
    logic         urdy_s[2];
    logic         u_re_s[2], u_we_s[2], evict_s[2], busy_s[2], err_s[2];
    logic [1:0]   chsel_s[2];
    logic [N-1:0] fill_s[2], sd_s[2], done_s[2];

    mem_miss_controller #(.NUM_CH(N), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_s[0]), .req_we_i(we_s[0]),
        .req_dirty_i(dirty_s[0]), .u_rdy_i(urdy_s[0]), .u_re_o(u_re_s[0]),
        .u_we_o(u_we_s[0]), .evict_o(evict_s[0]), .ch_sel_o(chsel_s[0]),
        .fill_we_o(fill_s[0]), .set_dirty_o(sd_s[0]), .done_o(done_s[0]),
        .busy_o(busy_s[0]), .err_o(err_s[0])
    );

    mem_miss_controller #(.NUM_CH(N), .ARB_MODE(0), .TIMEOUT_CYC(TO)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_s[1]), .req_we_i(we_s[1]),
        .req_dirty_i(dirty_s[1]), .u_rdy_i(urdy_s[1]), .u_re_o(u_re_s[1]),
        .u_we_o(u_we_s[1]), .evict_o(evict_s[1]), .ch_sel_o(chsel_s[1]),
        .fill_we_o(fill_s[1]), .set_dirty_o(sd_s[1]), .done_o(done_s[1]),
        .busy_o(busy_s[1]), .err_o(err_s[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding miss, described by its phase
    // (0 none, 1 write-back, 2 fill, 3 commit, 4 abort) and cycles waited.
    int arb_mode[2] = '{1, 0};
    int m_phase[2], m_ch[2], m_wait[2], m_ptr[2];
    bit m_we[2], m_err[2];

    bit [N-1:0] pend[2], pwe[2], pdirty[2];
    int rdy_div = 2;

    logic [N-1:0] dir_req, dir_we, dir_dirty;
    logic         dir_rdy;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_ch[d] = 0; m_wait[d] = 0; m_ptr[d] = 0;
            m_we[d] = 1'b0; m_err[d] = 1'b0; pend[d] = '0;
        end
    endtask

    function automatic int pick(input int d, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (arb_mode[d] == 1) ? (m_ptr[d] + k) % N : k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        int c;
        case (m_phase[d])
            0: begin
                c = pick(d, req_s[d]);
                if (c >= 0) begin
                    m_ch[d]    = c;
                    m_we[d]    = we_s[d][c];
                    m_phase[d] = dirty_s[d][c] ? 1 : 2;
                    m_wait[d]  = 0;
                end
            end
            1, 2: begin
                if (urdy_s[d]) begin
                    m_phase[d] = m_phase[d] + 1;
                    m_wait[d]  = 0;
                end else if (TO != 0 && m_wait[d] + 1 == TO) begin
                    m_phase[d] = 4;
                    m_err[d]   = 1'b1;
                end else begin
                    m_wait[d] = m_wait[d] + 1;
                end
            end
            3: begin
                m_ptr[d]   = (m_ch[d] + 1) % N;
                m_phase[d] = 0;
            end
            default: m_phase[d] = 0;
        endcase
    endtask

    task automatic compare(input int d);
        logic [N-1:0] oh;
        oh = N'(1) << m_ch[d];
        check($sformatf("ctl%0d", d), {u_re_s[d], u_we_s[d], evict_s[d], busy_s[d], err_s[d]},
              {m_phase[d] == 2, m_phase[d] == 1, m_phase[d] == 1, m_phase[d] != 0, m_err[d]});
        check($sformatf("ch_sel%0d", d), chsel_s[d], m_ch[d]);
        check($sformatf("fill_we%0d", d), fill_s[d], (m_phase[d] == 3) ? oh : '0);
        check($sformatf("set_dirty%0d", d), sd_s[d], (m_phase[d] == 3 && m_we[d]) ? oh : '0);
        check($sformatf("done%0d", d), done_s[d], (m_phase[d] == 3 || m_phase[d] == 4) ? oh : '0);
        check($sformatf("re_we_excl%0d", d), u_re_s[d] & u_we_s[d], 0);
    endtask

    task automatic tick(input bit rnd);
        @(negedge clk);
        for (int d = 0; d < 2; d++) compare(d);
        for (int d = 0; d < 2; d++) begin
            if (rnd) begin
                logic [N-1:0] drop;
                pend[d] = pend[d] & ~done_s[d];
                for (int c = 0; c < N; c++) begin
                    if (!pend[d][c] && $urandom_range(0, 3) == 0) begin
                        pend[d][c]   = 1'b1;
                        pwe[d][c]    = 1'($urandom_range(0, 1));
                        pdirty[d][c] = 1'($urandom_range(0, 1));
                    end
                    drop[c] = ($urandom_range(0, 7) == 0);
                end
                req_s[d]   = pend[d] & ~drop;
                we_s[d]    = pwe[d];
                dirty_s[d] = pdirty[d];
                urdy_s[d]  = ($urandom_range(0, rdy_div - 1) == 0);
            end else begin
                req_s[d]   = dir_req;
                we_s[d]    = dir_we;
                dirty_s[d] = dir_dirty;
                urdy_s[d]  = dir_rdy;
            end
        end
        for (int d = 0; d < 2; d++) model_step(d);
    endtask

    bit sticky_err = 1'b0;

    // Single-channel miss; rdy arrives on the given wait cycle (0 = never, so the watchdog fires).
    task automatic run_miss(input int ch, input bit we, input bit dirty, input int wb_cyc, input int fill_cyc);
        logic [N-1:0] oh;
        bit ok, got;
        oh = N'(1) << ch;
        dir_req = oh; dir_we = we ? oh : '0; dir_dirty = dirty ? oh : '0; dir_rdy = 1'b0;
        tick(0);
        ok = 1'b1;
        if (dirty) begin
            got = 1'b0;
            for (int i = 1; i <= TO && !got; i++) begin
                dir_rdy = (i == wb_cyc);
                tick(0);
                for (int d = 0; d < 2; d++) check("wb_phase", {u_re_s[d], u_we_s[d], evict_s[d]}, 3'b011);
                if (i == wb_cyc) got = 1'b1;
            end
            ok = got;
        end
        if (ok) begin
            got = 1'b0;
            for (int i = 1; i <= TO && !got; i++) begin
                dir_rdy = (i == fill_cyc);
                tick(0);
                for (int d = 0; d < 2; d++) check("fill_phase", {u_re_s[d], u_we_s[d], evict_s[d]}, 3'b100);
                if (i == fill_cyc) got = 1'b1;
            end
            ok = got;
        end
        if (!ok) sticky_err = 1'b1;
        dir_req = '0; dir_rdy = 1'b0;
        tick(0);
        for (int d = 0; d < 2; d++) begin
            check("end_done", done_s[d], oh);
            check("end_fill", fill_s[d], ok ? oh : '0);
            check("end_set_dirty", sd_s[d], (ok && we) ? oh : '0);
            check("end_err", err_s[d], sticky_err);
        end
        tick(0);
        for (int d = 0; d < 2; d++) check("idle_busy", busy_s[d], 0);
    endtask

    int n_done[2];

    initial begin
        dir_req = '0; dir_we = '0; dir_dirty = '0; dir_rdy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = '0; we_s[d] = '0; dirty_s[d] = '0; urdy_s[d] = 1'b0;
        end
        model_reset();
        tick(0);
        tick(0);
        @(negedge clk);
        rst_n = 1'b1;

        run_miss(0, 1'b0, 1'b0, 0, 3);
        run_miss(1, 1'b1, 1'b1, 2, 1);
        run_miss(2, 1'b0, 1'b0, 0, TO);
        run_miss(3, 1'b1, 1'b0, 0, 0);
        run_miss(1, 1'b1, 1'b1, 1, 1);
        run_miss(0, 1'b0, 1'b1, 0, 0);

        rdy_div = 2;
        for (int i = 0; i < 1500; i++) tick(1);
        rdy_div = 7;
        for (int i = 0; i < 1500; i++) tick(1);

        dir_req = '0; dir_we = '0; dir_dirty = '0; dir_rdy = 1'b1;
        for (int i = 0; i < 12; i++) tick(0);
        dir_req = 4'b0010; dir_dirty = 4'b0010; dir_rdy = 1'b0;
        tick(0);
        tick(0);
        for (int d = 0; d < 2; d++) check("pre_rst_wb", u_we_s[d], 1);
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_s[d] = '0; we_s[d] = '0; dirty_s[d] = '0; urdy_s[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ctl", {u_re_s[d], u_we_s[d], evict_s[d], busy_s[d], err_s[d]}, 0);
            check("rst_outs", {chsel_s[d], fill_s[d], sd_s[d], done_s[d]}, 0);
        end
        model_reset();
        sticky_err = 1'b0;
        dir_req = '0; dir_dirty = '0; dir_rdy = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("rst_hold_done", done_s[d], 0);
        rst_n = 1'b1;

        dir_req = '1; dir_we = '0; dir_dirty = '0; dir_rdy = 1'b1;
        n_done[0] = 0; n_done[1] = 0;
        for (int i = 0; i < 16; i++) begin
            tick(0);
            for (int d = 0; d < 2; d++) begin
                if (done_s[d] != '0) begin
                    check($sformatf("arb_seq%0d", d), chsel_s[d], (d == 0) ? n_done[d] % N : 0);
                    n_done[d]++;
                end
            end
        end
        for (int d = 0; d < 2; d++) check($sformatf("arb_count%0d", d), n_done[d], 5);

        dir_req = '0; dir_rdy = 1'b0;
        tick(0);
        tick(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
